// File: rtl/ttl_serial_cmp_seq_pkg.sv
// Shared definitions for the nibble-serial comparator sequencer: state codes,
// cascade bundle type and the LSB cascade seed.
package ttl_serial_cmp_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cascade_t;

  // The least significant comparator step sees "equal so far".
  localparam cascade_t CASCADE_SEED = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};

  // Exactly one of the three comparator outputs may be high.
  function automatic logic is_one_hot(input cascade_t c);
    return (c.gt ^ c.eq ^ c.lt) & ~(c.gt & c.eq & c.lt);
  endfunction

endpackage

// File: rtl/ttl_serial_cmp_seq_nib_mux.sv
// W-to-4 nibble selector; nibble 0 is the least significant nibble of the word.
module ttl_nib_mux #(
  parameter int NIBBLES = 4,
  parameter int IW      = 4
) (
  input  logic [4*NIBBLES-1:0] word,
  input  logic [IW-1:0]        idx,
  output logic [3:0]           nib
);

  logic [3:0] nibs [NIBBLES];

  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_split
    assign nibs[gi] = word[4*gi +: 4];
  end

  // Out-of-range indices read as zero rather than aliasing another nibble.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) nib = nibs[i];
    end
  end

endmodule

// File: rtl/ttl_serial_cmp_seq.sv
// Drives an external 4-bit cascadable magnitude comparator one nibble pair per
// clock, LSB first, feeding each result back as the next step's cascade input.
module ttl_serial_cmp_seq
  import ttl_serial_cmp_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int IW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] opa,
  input  logic [4*NIBBLES-1:0] opb,
  output logic                 busy,
  output logic                 done,
  output logic                 res_gt,
  output logic                 res_eq,
  output logic                 res_lt,
  output logic                 err,
  output logic [3:0]           a_nib,
  output logic [3:0]           b_nib,
  output logic                 c_gt,
  output logic                 c_eq,
  output logic                 c_lt,
  input  logic                 cmp_gt,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt
);

  localparam int W = 4 * NIBBLES;

  logic [1:0]    state_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  opa_reg;
  logic [W-1:0]  opb_reg;
  cascade_t      cas_reg;
  cascade_t      res_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;

  cascade_t cmp_now;
  logic     last_step;

  assign cmp_now   = '{gt: cmp_gt, eq: cmp_eq, lt: cmp_lt};
  assign last_step = (idx_reg == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      cas_reg   <= CASCADE_SEED;
      res_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // DONE differs from IDLE only in name: both accept a new start at once.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            opa_reg   <= opa;
            opb_reg   <= opb;
            idx_reg   <= '0;
            cas_reg   <= CASCADE_SEED;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Raw comparator values propagate even when malformed; err just records it.
          cas_reg <= cmp_now;
          if (!is_one_hot(cmp_now)) err_reg <= 1'b1;
          if (last_step) begin
            res_reg   <= cmp_now;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            idx_reg   <= '0;
            state_reg <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  ttl_nib_mux #(.NIBBLES(NIBBLES), .IW(IW)) u_mux_a (
    .word (opa_reg),
    .idx  (idx_reg),
    .nib  (a_nib)
  );

  ttl_nib_mux #(.NIBBLES(NIBBLES), .IW(IW)) u_mux_b (
    .word (opb_reg),
    .idx  (idx_reg),
    .nib  (b_nib)
  );

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign res_gt = res_reg.gt;
  assign res_eq = res_reg.eq;
  assign res_lt = res_reg.lt;
  assign err    = err_reg;
  assign c_gt   = cas_reg.gt;
  assign c_eq   = cas_reg.eq;
  assign c_lt   = cas_reg.lt;

endmodule

// File: tb/tb_ttl_serial_cmp_seq.sv
// Bench for ttl_serial_cmp_seq: a behavioural 4-bit cascadable comparator closes
// the loop, and results are checked against whole-word integer comparisons.
module tb_ttl_serial_cmp_seq;

  localparam int N  = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [4*N-1:0] opa, opb;
  logic          busy, done, res_gt, res_eq, res_lt, err;
  logic [3:0]    a_nib, b_nib;
  logic          c_gt, c_eq, c_lt;
  logic          cmp_gt, cmp_eq, cmp_lt;
  logic          force_bad;

  int checks = 0;
  int errors = 0;

  always #25 clk = ~clk;

  ttl_serial_cmp_seq #(.NIBBLES(N), .IW(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opa    (opa),
    .opb    (opb),
    .busy   (busy),
    .done   (done),
    .res_gt (res_gt),
    .res_eq (res_eq),
    .res_lt (res_lt),
    .err    (err),
    .a_nib  (a_nib),
    .b_nib  (b_nib),
    .c_gt   (c_gt),
    .c_eq   (c_eq),
    .c_lt   (c_lt),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt)
  );

  // 74LS85-style behaviour: magnitude decides, equality passes the cascade through.
  always_comb begin
    if (force_bad)          {cmp_gt, cmp_eq, cmp_lt} = 3'b101;
    else if (a_nib > b_nib) {cmp_gt, cmp_eq, cmp_lt} = 3'b100;
    else if (a_nib < b_nib) {cmp_gt, cmp_eq, cmp_lt} = 3'b001;
    else                    {cmp_gt, cmp_eq, cmp_lt} = {c_gt, c_eq, c_lt};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] word_cmp(input logic [4*N-1:0] a, input logic [4*N-1:0] b);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full compare; inject_k >= 0 corrupts the comparator sample for that nibble.
  task automatic run_cmp(input logic [4*N-1:0] a, input logic [4*N-1:0] b, input int inject_k);
    logic [4*N-1:0] mask;
    logic [2:0]     exp_res;
    opa   = a;
    opb   = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("err_clear", 32'(err), 32'd0);
    check("cas_seed", 32'({c_gt, c_eq, c_lt}), 32'b010);
    for (int k = 0; k < N; k++) begin
      check("a_nib", 32'(a_nib), 32'(a[4*k +: 4]));
      check("b_nib", 32'(b_nib), 32'(b[4*k +: 4]));
      force_bad = (k == inject_k);
      tick();
      force_bad = 1'b0;
      check("err_flag", 32'(err), 32'((inject_k >= 0) && (k >= inject_k)));
      if (inject_k < 0) begin
        mask = {(4*N){1'b1}} >> (4 * (N - 1 - k));
        check("cascade", 32'({c_gt, c_eq, c_lt}), 32'(word_cmp(a & mask, b & mask)));
      end else if (k == inject_k) begin
        check("cascade_raw", 32'({c_gt, c_eq, c_lt}), 32'b101);
      end
      if (k < N - 1) check("run_flags", 32'({busy, done}), 32'b10);
      else           check("done_flags", 32'({busy, done}), 32'b01);
    end
    exp_res = word_cmp(a, b);
    check("result", 32'({res_gt, res_eq, res_lt}), 32'(exp_res));
    $display("compare a=%h b=%h gt/eq/lt=%b%b%b err=%b", a, b, res_gt, res_eq, res_lt, err);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("result_hold", 32'({res_gt, res_eq, res_lt}), 32'(exp_res));
  endtask

  initial begin
    logic [4*N-1:0] ra, rb;
    int done_cnt;
    int done_edge [2];

    rst       = 1'b1;
    start     = 1'b0;
    force_bad = 1'b0;
    opa       = '0;
    opb       = '0;
    tick();
    tick();
    check("rst_flags", 32'({busy, done, err}), 32'b000);
    check("rst_res", 32'({res_gt, res_eq, res_lt}), 32'b000);
    check("rst_cas", 32'({c_gt, c_eq, c_lt}), 32'b010);
    check("rst_nib", 32'({a_nib, b_nib}), 32'h00);
    rst = 1'b0;
    tick();

    // Directed vectors
    run_cmp(16'h1234, 16'h1234, -1);
    run_cmp(16'h8000, 16'h7FFF, -1);
    run_cmp(16'h0010, 16'h0001, -1);
    run_cmp(16'h0001, 16'h0010, -1);

    // Malformed comparator sample on nibble 0; top nibble still decides the result
    run_cmp(16'h5000, 16'h4000, 0);
    check("err_sticky_after_done", 32'(err), 32'd1);
    run_cmp(16'h0F0F, 16'h0F0F, -1);

    // Back-to-back with start held, operand changes and start pulses while busy
    opa = 16'hA5A5;
    opb = 16'hA5A4;
    done_cnt = 0;
    done_edge[0] = 0;
    done_edge[1] = 0;
    for (int e = 1; e <= 3*N + 4; e++) begin
      if (e <= N + 2)          start = 1'b1;
      else if (e <= 2*N + 1)   start = 1'(e % 2);
      else                     start = 1'b0;
      if (e == 2) begin
        opa = 16'h0F00;
        opb = 16'h1000;
      end
      tick();
      if (done) begin
        if (done_cnt < 2) done_edge[done_cnt] = e;
        if (done_cnt == 0) check("b2b_res1", 32'({res_gt, res_eq, res_lt}), 32'b100);
        if (done_cnt == 1) check("b2b_res2", 32'({res_gt, res_eq, res_lt}), 32'b001);
        done_cnt++;
        $display("back-to-back done #%0d at edge %0d", done_cnt, e);
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(done_cnt), 32'd2);
    check("b2b_edge1", 32'(done_edge[0]), 32'(N + 1));
    check("b2b_edge2", 32'(done_edge[1]), 32'(2*N + 2));

    // Reset during the second RUN cycle aborts the compare
    opa   = 16'h1234;
    opb   = 16'h1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_flags", 32'({busy, done, err}), 32'b000);
    check("abort_cas", 32'({c_gt, c_eq, c_lt}), 32'b010);
    check("abort_res", 32'({res_gt, res_eq, res_lt}), 32'b000);
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("abort_no_done", 32'({busy, done}), 32'b00);
    end
    $display("reset abort completed");
    run_cmp(16'h1234, 16'h1111, -1);

    // Randomized compares with frequently shared nibbles
    for (int t = 0; t < 24; t++) begin
      ra = 16'($urandom);
      rb = ra;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(1, 0) == 1) rb[4*k +: 4] = 4'($urandom);
      end
      run_cmp(ra, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
